serial_frame_rx: RTL and testbench

Serial-to-parallel frame receiver. It sits directly downstream of the `dff_sync_res` input synchroniser and consumes its registered `Q` bit stream. Each frame carries a start bit, `DATA_W` data bits (LSB first), a parity bit and a stop bit. The receiver checks the frame and presents the data word with a one-cycle valid pulse and error flags.

---
 rtl/serial_frame_rx_pkg.sv | 17 +
 rtl/serial_frame_rx_sipo.sv | 24 ++
 rtl/serial_frame_rx.sv | 125 ++++++++++++
 tb/tb_serial_frame_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver and its companion transmitter.
// The line-state encodings are fixed 2-bit values so both ends agree on them.
package serial_frame_rx_pkg;

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = RX_IDLE,
    ST_DATA   = RX_DATA,
    ST_PARITY = RX_PARITY,
    ST_STOP   = RX_STOP
  } rx_state_e;

endpackage

// File: rtl/serial_frame_rx_sipo.sv
// Serial-in parallel-out shift register: new bits enter at the MSB and move
// toward bit 0, so the first bit received ends up in bit 0.
module sipo_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              async_reset_n,
  input  logic              shift_en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  // Shift register state.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[DATA_W-1:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Delivers the word with a one-cycle valid pulse plus parity and framing flags.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              async_reset_n,
  input  logic              serial_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // High when the data bits plus the parity bit do not match the selected parity.
  function automatic logic frame_parity_err(input logic [DATA_W-1:0] data, input logic par_bit);
    return (^data) ^ par_bit ^ PARITY_ODD;
  endfunction

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_par_bit;
  logic              w_par_nxt;
  logic              w_shift_en;
  logic [DATA_W-1:0] w_shift_q;
  logic              w_stop_ok;
  logic              w_stop_bad;

  sipo_shift_reg #(
    .DATA_W(DATA_W)
  ) u_sipo (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .shift_en     (w_shift_en),
    .din          (serial_in),
    .q            (w_shift_q)
  );

  // Next-state, counter and parity-capture logic; nothing moves without bit_en.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par_bit;
    w_shift_en  = 1'b0;
    if (bit_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!serial_in) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          w_shift_en = 1'b1;
          w_cnt_nxt  = r_cnt + CNT_W'(1'b1);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_PARITY: begin
          w_par_nxt   = serial_in;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_stop_ok  = bit_en && (r_state == ST_STOP) &&  serial_in;
  assign w_stop_bad = bit_en && (r_state == ST_STOP) && !serial_in;

  // FSM state, bit counter and captured parity bit.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_par_bit <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_par_bit <= w_par_nxt;
    end
  end

  // Registered outputs; the pulses clear on every edge they are not re-asserted.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= w_stop_ok;
      frame_err  <= w_stop_bad;
      busy       <= (w_state_nxt != ST_IDLE);
      if (w_stop_ok) begin
        data_out   <= w_shift_q;
        parity_err <= frame_parity_err(w_shift_q, r_par_bit);
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: even- and odd-parity instances share one line.
module tb_serial_frame_rx;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sin;
  logic ben;
  logic [DW-1:0] dout_e, dout_o;
  logic val_e, val_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .async_reset_n(rst_n), .serial_in(sin), .bit_en(ben),
    .data_out(dout_e), .data_valid(val_e), .parity_err(perr_e),
    .frame_err(ferr_e), .busy(busy_e));

  serial_frame_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .async_reset_n(rst_n), .serial_in(sin), .bit_en(ben),
    .data_out(dout_o), .data_valid(val_o), .parity_err(perr_o),
    .frame_err(ferr_o), .busy(busy_o));

  typedef struct {
    logic [7:0] word;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_perr_e;
    logic       exp_perr_o;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  // reference model state
  logic       m_in_frame;
  logic       m_q[$];
  logic [7:0] m_data;
  logic       m_valid, m_perr_e, m_perr_o, m_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b_en, input logic b);
    sin = b;
    ben = b_en;
    @(posedge clk);
    #1;
    busy_cnt += int'(busy_e);
  endtask

  task automatic send_frame(input logic [7:0] word, input logic par, input logic stop);
    step(1'b1, 1'b0);
    for (int i = 0; i < DW; i++) step(1'b1, word[i]);
    step(1'b1, par);
    step(1'b1, stop);
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_q.delete();
    m_data   = '0;
    m_valid  = 1'b0;
    m_perr_e = 1'b0;
    m_perr_o = 1'b0;
    m_ferr   = 1'b0;
  endtask

  // Decode frames from the list of strobed samples.
  task automatic model_step(input logic be, input logic b);
    logic [7:0] w;
    int         ones;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (be) begin
      if (!m_in_frame) begin
        if (b == 1'b0) begin
          m_in_frame = 1'b1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(b);
        if (m_q.size() == DW + 2) begin
          m_in_frame = 1'b0;
          for (int i = 0; i < DW; i++) w[i] = m_q[i];
          if (m_q[DW + 1]) begin
            ones     = $countones(w) + int'(m_q[DW]);
            m_data   = w;
            m_valid  = 1'b1;
            m_perr_e = (ones % 2) != 0;
            m_perr_o = (ones % 2) == 0;
          end else begin
            m_ferr = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    logic       b;
    logic       be;
    logic       bitq[$];
    logic [7:0] w;
    int         t1, t2;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n    = 1'b0;
    sin      = 1'b1;
    ben      = 1'b0;
    busy_cnt = 0;
    #12;
    check("reset_outputs", 32'({dout_e, val_e, perr_e, ferr_e, busy_e}), 32'd0);
    check("reset_outputs_odd", 32'({dout_o, val_o, perr_o, ferr_o, busy_o}), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Table of single frames at one bit per clock.
    for (int i = 0; i < 7; i++) begin
      busy_cnt = 0;
      send_frame(vecs[i].word, vecs[i].par, vecs[i].stop);
      check("tbl_data",     32'(dout_e), 32'(vecs[i].exp_data));
      check("tbl_data_odd", 32'(dout_o), 32'(vecs[i].exp_data));
      check("tbl_valid",    32'(val_e),  32'(vecs[i].exp_valid));
      check("tbl_perr",     32'(perr_e), 32'(vecs[i].exp_perr_e));
      check("tbl_perr_odd", 32'(perr_o), 32'(vecs[i].exp_perr_o));
      check("tbl_ferr",     32'(ferr_e), 32'(vecs[i].exp_ferr));
      // busy spans the DATA, PARITY and STOP states
      check("tbl_busy_cycles", 32'(busy_cnt), 32'(DW + 2));
      step(1'b1, 1'b1);
      check("tbl_valid_width", 32'(val_e), 32'd0);
      check("tbl_ferr_width",  32'(ferr_e), 32'd0);
    end

    // Back-to-back frames with no idle bit.
    send_frame(8'hFF, 1'b0, 1'b1);
    t1 = cyc;
    check("b2b_first_valid", 32'(val_e), 32'd1);
    check("b2b_first_data",  32'(dout_e), 32'hFF);
    send_frame(8'h00, 1'b0, 1'b1);
    t2 = cyc;
    check("b2b_second_valid", 32'(val_e), 32'd1);
    check("b2b_second_data",  32'(dout_e), 32'h00);
    check("b2b_spacing", 32'(t2 - t1), 32'd11);

    // Strobe every third cycle, noise on the line between strobes.
    w = 8'h5A;
    for (int i = 0; i < DW + 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'($urandom_range(0, 1)));
      if (i == 0)           b = 1'b0;
      else if (i <= DW)     b = w[i - 1];
      else if (i == DW + 1) b = 1'b0;
      else                  b = 1'b1;
      step(1'b1, b);
      if (i == DW) check("gap_busy_held", 32'(busy_e), 32'd1);
    end
    check("gap_valid", 32'(val_e), 32'd1);
    check("gap_data",  32'(dout_e), 32'h5A);
    check("gap_perr",  32'(perr_e), 32'd0);
    step(1'b0, 1'($urandom_range(0, 1)));
    check("gap_valid_width", 32'(val_e), 32'd0);
    check("gap_data_hold",   32'(dout_e), 32'h5A);

    // Asynchronous reset after the fourth data bit.
    w = 8'hC3;
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, w[i]);
    check("midrst_busy_before", 32'(busy_e), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({dout_e, val_e, perr_e, ferr_e, busy_e}), 32'd0);
    #4;
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    check("midrst_next_valid", 32'(val_e), 32'd1);
    check("midrst_next_data",  32'(dout_e), 32'h81);
    check("midrst_next_perr",  32'(perr_e), 32'd0);

    // Random line traffic against the frame-level model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      if (bitq.size() == 0) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) bitq.push_back(1'b1);
        bitq.push_back(1'b0);
        for (int i = 0; i < DW + 1; i++) bitq.push_back(1'($urandom_range(0, 1)));
        bitq.push_back($urandom_range(0, 7) != 0);
      end
      be = ($urandom_range(0, 2) != 0);
      if (be) b = bitq.pop_front();
      else    b = 1'($urandom_range(0, 1));
      step(be, b);
      model_step(be, b);
      check("rnd_data",     32'(dout_e), 32'(m_data));
      check("rnd_data_odd", 32'(dout_o), 32'(m_data));
      check("rnd_valid",    32'(val_e),  32'(m_valid));
      check("rnd_perr",     32'(perr_e), 32'(m_perr_e));
      check("rnd_perr_odd", 32'(perr_o), 32'(m_perr_o));
      check("rnd_ferr",     32'(ferr_e), 32'(m_ferr));
      check("rnd_busy",     32'(busy_e), 32'(m_in_frame));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
